// File: rtl/reg_wb_arbiter.sv
// Register-file write-port owner: post-reset init sweep, then round-robin between WB and multicycle.
// Optional define WB_ARB_BYPASS_EN adds same-cycle forwarding of the in-flight write.
module reg_wb_arbiter #(
   parameter int unsigned NUM_REGS         = 32,
   parameter logic [31:0] LOW_INIT_VAL     = 32'h0232_8021,
   parameter logic [31:0] HIGH_INIT_VAL    = 32'h0000_000A,
   parameter int unsigned LOW_INIT_LAST    = 6,
   parameter bit          ZERO_REG_PROTECT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        write_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        init_done,
   output logic [15:0] conflict_cnt
`ifdef WB_ARB_BYPASS_EN
   ,
   input  logic [4:0]  fwd_addr1,
   input  logic [4:0]  fwd_addr2,
   output logic        fwd_hit1,
   output logic        fwd_hit2,
   output logic [31:0] fwd_data1,
   output logic [31:0] fwd_data2
`endif
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e     state_q;
   logic [4:0] cnt_q;
   logic       rr_ptr_q;
   logic       drop0;
   logic       drop1;

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (reset && state_q == StRun) begin
         req0_ready = req0_valid && (!req1_valid || !rr_ptr_q);
         req1_ready = req1_valid && (!req0_valid ||  rr_ptr_q);
      end
   end

   // Writes to r0 are handshaken normally but never reach the register file.
   assign drop0 = ZERO_REG_PROTECT && (req0_addr == 5'd0);
   assign drop1 = ZERO_REG_PROTECT && (req1_addr == 5'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StInit;
         cnt_q        <= 5'd0;
         rr_ptr_q     <= 1'b0;
         write_en     <= 1'b0;
         wr_addr      <= 5'd0;
         wr_data      <= 32'd0;
         init_done    <= 1'b0;
         conflict_cnt <= 16'd0;
      end else begin
         unique case (state_q)
            StInit: begin
               write_en <= 1'b1;
               wr_addr  <= cnt_q;
               wr_data  <= (32'(cnt_q) <= LOW_INIT_LAST) ? LOW_INIT_VAL : HIGH_INIT_VAL;
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'(NUM_REGS - 1)) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               init_done <= 1'b1;
               write_en  <= 1'b0;
               if (req0_ready) begin
                  write_en <= !drop0;
                  wr_addr  <= req0_addr;
                  wr_data  <= req0_data;
                  rr_ptr_q <= 1'b1;
               end else if (req1_ready) begin
                  write_en <= !drop1;
                  wr_addr  <= req1_addr;
                  wr_data  <= req1_data;
                  rr_ptr_q <= 1'b0;
               end
               if (req0_valid && req1_valid && conflict_cnt != 16'hFFFF) begin
                  conflict_cnt <= conflict_cnt + 16'd1;
               end
            end
            default: state_q <= StInit;
         endcase
      end
   end

`ifdef WB_ARB_BYPASS_EN
   assign fwd_hit1  = write_en && (wr_addr == fwd_addr1) && (wr_addr != 5'd0);
   assign fwd_hit2  = write_en && (wr_addr == fwd_addr2) && (wr_addr != 5'd0);
   assign fwd_data1 = wr_data;
   assign fwd_data2 = wr_data;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: init sweep, round-robin, r0 protect, reset restart.
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        write_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        init_done;
   logic [15:0] conflict_cnt;
`ifdef WB_ARB_BYPASS_EN
   logic [4:0]  fwd_addr1, fwd_addr2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
`endif

   int vectors = 0;
   int miscompares = 0;

   reg_wb_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_addr    (req0_addr),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_addr    (req1_addr),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .write_en     (write_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .init_done    (init_done),
      .conflict_cnt (conflict_cnt)
`ifdef WB_ARB_BYPASS_EN
      ,
      .fwd_addr1    (fwd_addr1),
      .fwd_addr2    (fwd_addr2),
      .fwd_hit1     (fwd_hit1),
      .fwd_hit2     (fwd_hit2),
      .fwd_data1    (fwd_data1),
      .fwd_data2    (fwd_data2)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
      chk({tag, ".write_en"}, 32'(write_en), 32'(we));
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
      chk({tag, ".wr_data"}, wr_data, d);
   endtask

   task automatic chk_rdy(input string tag, input logic r0, input logic r1);
      chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
      chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
   endtask

   task automatic sweep_check(input int last);
      for (int i = 0; i <= last; i++) begin
         step();
         chk_out($sformatf("sweep%0d", i), 1'b1, 5'(i),
                 (i <= 6) ? 32'h0232_8021 : 32'h0000_000A);
         chk($sformatf("sweep%0d.init_done", i), 32'(init_done), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef WB_ARB_BYPASS_EN
      fwd_addr1 = '0; fwd_addr2 = '0;
`endif
      repeat (3) step();
      chk_out("reset", 1'b0, 5'd0, 32'd0);
      chk("reset.init_done", 32'(init_done), 32'd0);
      chk("reset.conflict_cnt", 32'(conflict_cnt), 32'd0);
      chk_rdy("reset", 1'b0, 1'b0);

      // Both requesters pushing during the sweep: never granted, never counted.
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd3;
      req1_valid = 1'b1; req1_addr = 5'd4;
      for (int i = 0; i < 32; i++) begin
         step();
         chk_out($sformatf("init%0d", i), 1'b1, 5'(i),
                 (i <= 6) ? 32'h0232_8021 : 32'h0000_000A);
         chk_rdy($sformatf("init%0d", i), 1'b0, 1'b0);
         chk($sformatf("init%0d.init_done", i), 32'(init_done), 32'd0);
         if (i == 30) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
      step();
      chk("run.init_done", 32'(init_done), 32'd1);
      chk("run.idle_we", 32'(write_en), 32'd0);
      chk("run.conflict_cnt", 32'(conflict_cnt), 32'd0);

      // req0 alone
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
      #1 chk_rdy("r0only", 1'b1, 1'b0);
      step();
      req0_valid = 1'b0;
      chk_out("r0only.wr", 1'b1, 5'd5, 32'hDEAD_BEEF);

      // req1 alone puts rr_ptr back to 0
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_0077;
      #1 chk_rdy("r1only", 1'b0, 1'b1);
      step();
      req1_valid = 1'b0;
      chk_out("r1only.wr", 1'b1, 5'd7, 32'h0000_0077);

      // Both valid for 4 cycles: req0, req1, req0, req1
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0333;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0444;
      #1 chk_rdy("rr0", 1'b1, 1'b0);
      step();
      chk_out("rr0.wr", 1'b1, 5'd3, 32'h0000_0333);
      chk_rdy("rr1", 1'b0, 1'b1);
      step();
      chk_out("rr1.wr", 1'b1, 5'd4, 32'h0000_0444);
      chk_rdy("rr2", 1'b1, 1'b0);
      step();
      chk_out("rr2.wr", 1'b1, 5'd3, 32'h0000_0333);
      chk_rdy("rr3", 1'b0, 1'b1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk_out("rr3.wr", 1'b1, 5'd4, 32'h0000_0444);
      chk("rr.conflict_cnt", 32'(conflict_cnt), 32'd4);
      step();
      chk_out("idle.hold", 1'b0, 5'd4, 32'h0000_0444);

      // r0 write accepted but dropped
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
      #1 chk_rdy("zero", 1'b0, 1'b1);
      step();
      req1_valid = 1'b0;
      chk("zero.write_en", 32'(write_en), 32'd0);
      chk("zero.conflict_cnt", 32'(conflict_cnt), 32'd4);

      // Reset from RUN clears init_done and the counter
      reset = 1'b0;
      step();
      chk_out("rst2", 1'b0, 5'd0, 32'd0);
      chk("rst2.init_done", 32'(init_done), 32'd0);
      chk("rst2.conflict_cnt", 32'(conflict_cnt), 32'd0);
      reset = 1'b1;
      sweep_check(12);

      // Reset mid-sweep at addr 12 restarts from 0
      reset = 1'b0;
      step();
      chk_out("rst3", 1'b0, 5'd0, 32'd0);
      chk_rdy("rst3", 1'b0, 1'b0);
      reset = 1'b1;
      sweep_check(31);
      step();
      chk("rerun.init_done", 32'(init_done), 32'd1);

`ifdef WB_ARB_BYPASS_EN
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hCAFE_0009;
      step();
      req0_valid = 1'b0;
      fwd_addr1 = 5'd9; fwd_addr2 = 5'd0;
      #1;
      chk_out("fwd.wr", 1'b1, 5'd9, 32'hCAFE_0009);
      chk("fwd.hit1", 32'(fwd_hit1), 32'd1);
      chk("fwd.data1", fwd_data1, 32'hCAFE_0009);
      chk("fwd.hit2", 32'(fwd_hit2), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Sole owner of the register file write port (write_en, wr_addr, wr_data).
- After reset it runs an initialisation sweep that loads every register with a programmed value.
- It then shares the write port between two write-back requesters using round-robin arbitration: req0 is the pipeline WB stage, req1 is the multicycle unit (load/mul-div).
- All write-port outputs are registered, giving one cycle of latency from handshake to register file write.

Parameters:
- NUM_REGS, 32, number of registers swept during init; power of two, ≤32.
- LOW_INIT_VAL, 32'h0232_8021, init value for registers 0..LOW_INIT_LAST.
- HIGH_INIT_VAL, 32'h0000_000A, init value for registers above LOW_INIT_LAST.
- LOW_INIT_LAST, 6, last register index that receives LOW_INIT_VAL.
- ZERO_REG_PROTECT, 1, 1 = run-time writes to register 0 are accepted but dropped.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous reset, active-low
- req0_valid  in  1  WB-stage write request
- req0_addr  in  5  destination register
- req0_data  in  32  write data
- req0_ready  out  1  req0 accepted this cycle
- req1_valid  in  1  multicycle-unit write request
- req1_addr  in  5  destination register
- req1_data  in  32  write data
- req1_ready  out  1  req1 accepted this cycle
- write_en  out  1  to register file
- wr_addr  out  5  to register file
- wr_data  out  32  to register file
- init_done  out  1  high once the init sweep completes
- conflict_cnt  out  16  saturating count of cycles where a valid requester was refused

Behaviour:
- Reset (reset==0 at posedge):
  - state=INIT, sweep counter=0, rr_ptr=0.
  - write_en=0, wr_addr=0, wr_data=0, init_done=0, conflict_cnt=0.
  - req*_ready=0 while reset is low.
  - Reset asserted mid-sweep or mid-run restarts the sweep from 0. Any accepted-but-unwritten request is discarded.
- INIT state, one register per cycle:
  - Register outputs write_en=1, wr_addr=cnt, wr_data = (cnt≤LOW_INIT_LAST ? LOW_INIT_VAL : HIGH_INIT_VAL).
  - ZERO_REG_PROTECT does not apply during INIT.
  - Counter increments each cycle. Once cnt reaches NUM_REGS-1, transition to RUN.
  - First init write is visible on the outputs in the cycle after reset deasserts. Exactly NUM_REGS consecutive write_en=1 cycles.
  - req0_ready = req1_ready = 0 throughout INIT. Requests are not counted as conflicts.
- RUN state:
  - init_done=1 from the first RUN cycle until reset.
  - readies are combinational from valids, state and rr_ptr:
    - only reqN_valid high -> reqN_ready=1.
    - both valid -> ready to the side selected by rr_ptr (0 -> req0, 1 -> req1).
  - After any grant to side N, rr_ptr = ~N. With no grant, rr_ptr holds.
  - Accepted request: the next cycle shows write_en=1, wr_addr=addr, wr_data=data.
  - ZERO_REG_PROTECT=1 and addr==0: ready is still given, but write_en=0 in the next cycle.
  - No accept -> write_en=0 next cycle. wr_addr/wr_data hold their last value.
  - Throughput is one write per cycle. Requesters hold valid/addr/data stable until ready; the block does not check this.
- conflict_cnt: +1 on each RUN cycle where both valids are high (one side refused). Saturates at 16'hFFFF. Cleared only by reset.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- When defined, add ports:
  - fwd_addr1, fwd_addr2 (in, 5)
  - fwd_hit1, fwd_hit2 (out, 1)
  - fwd_data1, fwd_data2 (out, 32)
- fwd_hitK = write_en && wr_addr==fwd_addrK && wr_addr!=0. fwd_dataK = wr_data. Both are combinational.
- Lets decode see the value being written this cycle.
- When not defined: these ports are absent, and there is no extra logic.

Test Plan:
- Hold reset low 3 cycles, then release -> 32 consecutive writes: addr 0..31, data 32'h02328021 for addr 0..6 and 32'h0000000A for addr 7..31. init_done rises the cycle after addr 31. Readies stay low throughout.
- RUN, req0 only (addr 5, data 32'hDEADBEEF) -> req0_ready=1 the same cycle. Next cycle write_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
- RUN, both valid for 4 cycles (req0 addr 3, req1 addr 4), rr_ptr=0 -> grants go req0, req1, req0, req1. conflict_cnt=4.
- req1 writes addr 0, data 32'h1234 with ZERO_REG_PROTECT=1 -> req1_ready=1, and write_en stays 0 the next cycle.
- Reset asserted during sweep at addr 12 -> outputs clear. After release the sweep restarts at addr 0 and init_done returns to 0.
- With WB_ARB_BYPASS_EN: write to addr 9 in flight, fwd_addr1=9, fwd_addr2=0 -> fwd_hit1=1, fwd_data1=wr_data, fwd_hit2=0.
